// File: rtl/mem_map_pkg.sv
// Shared definitions for the Z80 S100 SBC memory-map decoder: FSM encoding,
// default region indices, the shadow-disable I/O port and the wait-count width.
package mem_map_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ACTIVE = 2'd2
  } state_e;

  localparam int         ROM_IDX          = 0;
  localparam int         VGA_IDX          = 1;
  localparam logic [7:0] SHADOW_PORT_DEF  = 8'hFE;
  localparam int         WAIT_W           = 4;

endpackage

// File: rtl/mem_map_decoder_region_match.sv
// Combinational priority matcher: turns the decoded top address bits into a
// one-hot region hit, a fallback hit, a read-only fault and the wait count.
module region_match
  import mem_map_pkg::*;
#(
  parameter int                            DEC_BITS     = 4,
  parameter int                            NUM_REGIONS  = 3,
  parameter logic [DEC_BITS*NUM_REGIONS-1:0] REGION_BASE = 12'h0EF,
  parameter logic [DEC_BITS*NUM_REGIONS-1:0] REGION_MASK = 12'h0FF,
  parameter logic [WAIT_W*NUM_REGIONS-1:0]   REGION_WAIT = 12'h021,
  parameter logic [NUM_REGIONS-1:0]          REGION_RO   = 3'b001,
  parameter int                            DEFAULT_WAIT = 0
) (
  input  logic [DEC_BITS-1:0]    top,
  input  logic                   shadow,
  input  logic                   is_write,
  output logic [NUM_REGIONS-1:0] hit,
  output logic                   default_hit,
  output logic                   ro_fault,
  output logic [WAIT_W-1:0]      wait_cnt
);

  logic [NUM_REGIONS-1:0] hit_s;
  logic                   found_s;
  logic                   ro_s;
  logic [WAIT_W-1:0]      wait_s;

  // Lowest matching index wins; a slot with an all-zero mask is unpopulated
  // and never matches, so default parameters leave slot 2 unused.
  always_comb begin
    hit_s       = '0;
    found_s     = 1'b0;
    ro_s        = 1'b0;
    wait_s      = '0;
    hit         = '0;
    default_hit = 1'b0;
    ro_fault    = 1'b0;
    wait_cnt    = '0;
    for (int i = 0; i < NUM_REGIONS; i++) begin
      if (!found_s && (REGION_MASK[i*DEC_BITS +: DEC_BITS] != '0) &&
          ((top & REGION_MASK[i*DEC_BITS +: DEC_BITS]) ==
           (REGION_BASE[i*DEC_BITS +: DEC_BITS] & REGION_MASK[i*DEC_BITS +: DEC_BITS]))) begin
        hit_s[i] = 1'b1;
        found_s  = 1'b1;
        ro_s     = REGION_RO[i];
        wait_s   = REGION_WAIT[i*WAIT_W +: WAIT_W];
      end else begin
        hit_s = hit_s;
      end
    end
    if (shadow && (top == '0)) begin
      hit_s          = '0;
      hit_s[ROM_IDX] = 1'b1;
      found_s        = 1'b1;
      ro_s           = REGION_RO[ROM_IDX];
      wait_s         = REGION_WAIT[ROM_IDX*WAIT_W +: WAIT_W];
    end else begin
      found_s = found_s;
    end
    if (found_s && ro_s && is_write) begin
      ro_fault = 1'b1;
    end else if (found_s) begin
      hit      = hit_s;
      wait_cnt = wait_s;
    end else begin
      default_hit = 1'b1;
      wait_cnt    = WAIT_W'(DEFAULT_WAIT);
    end
  end

endmodule

// File: rtl/mem_map_decoder.sv
// Memory-map decoder top: access FSM, registered chip selects, wait-state
// counter and the boot-ROM shadow flag.
module mem_map_decoder
  import mem_map_pkg::*;
#(
  parameter int                              ADDR_W       = 16,
  parameter int                              DEC_BITS     = 4,
  parameter int                              NUM_REGIONS  = 3,
  parameter logic [DEC_BITS*NUM_REGIONS-1:0] REGION_BASE  = 12'h0EF,
  parameter logic [DEC_BITS*NUM_REGIONS-1:0] REGION_MASK  = 12'h0FF,
  parameter logic [WAIT_W*NUM_REGIONS-1:0]   REGION_WAIT  = 12'h021,
  parameter logic [NUM_REGIONS-1:0]          REGION_RO    = 3'b001,
  parameter int                              DEFAULT_WAIT = 0,
  parameter logic [7:0]                      SHADOW_PORT  = SHADOW_PORT_DEF
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [ADDR_W-1:0]      address,
  input  logic                   memread,
  input  logic                   memwrite,
  input  logic                   iowrite,
  input  logic [7:0]             ioaddr,
  input  logic                   mem_en,
  output logic [NUM_REGIONS-1:0] region_cs,
  output logic                   default_cs,
  output logic                   ready,
  output logic                   boot_shadow,
  output logic                   write_fault
);

  state_e                 state_r;
  logic [WAIT_W-1:0]      wait_cnt_r;
  logic                   req_s;
  logic [DEC_BITS-1:0]    top_s;
  logic [NUM_REGIONS-1:0] hit_s;
  logic                   default_hit_s;
  logic                   ro_fault_s;
  logic [WAIT_W-1:0]      wait_s;
  logic                   unused_addr_s;

  assign req_s         = (memread | memwrite) & mem_en;
  assign top_s         = address[ADDR_W-1 -: DEC_BITS];
  assign unused_addr_s = ^address[ADDR_W-DEC_BITS-1:0];

  region_match #(
    .DEC_BITS    (DEC_BITS),
    .NUM_REGIONS (NUM_REGIONS),
    .REGION_BASE (REGION_BASE),
    .REGION_MASK (REGION_MASK),
    .REGION_WAIT (REGION_WAIT),
    .REGION_RO   (REGION_RO),
    .DEFAULT_WAIT(DEFAULT_WAIT)
  ) u_match (
    .top        (top_s),
    .shadow     (boot_shadow),
    .is_write   (memwrite),
    .hit        (hit_s),
    .default_hit(default_hit_s),
    .ro_fault   (ro_fault_s),
    .wait_cnt   (wait_s)
  );

  // Access FSM; the selects captured at the start edge are the latched decode
  // and are held unchanged until the access ends.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      wait_cnt_r  <= '0;
      region_cs   <= '0;
      default_cs  <= 1'b0;
      ready       <= 1'b1;
      boot_shadow <= 1'b1;
      write_fault <= 1'b0;
    end else begin
      write_fault <= 1'b0;
      if (iowrite && (ioaddr == SHADOW_PORT)) begin
        boot_shadow <= 1'b0;
      end
      case (state_r)
        ST_IDLE: begin
          if (req_s) begin
            region_cs   <= hit_s;
            default_cs  <= default_hit_s;
            write_fault <= ro_fault_s;
            if (wait_s != '0) begin
              ready      <= 1'b0;
              wait_cnt_r <= wait_s;
              state_r    <= ST_WAIT;
            end else begin
              state_r <= ST_ACTIVE;
            end
          end
        end
        ST_WAIT: begin
          if (!req_s) begin
            region_cs  <= '0;
            default_cs <= 1'b0;
            ready      <= 1'b1;
            wait_cnt_r <= '0;
            state_r    <= ST_IDLE;
          end else if (wait_cnt_r == WAIT_W'(1)) begin
            ready      <= 1'b1;
            wait_cnt_r <= '0;
            state_r    <= ST_ACTIVE;
          end else begin
            wait_cnt_r <= wait_cnt_r - WAIT_W'(1);
          end
        end
        ST_ACTIVE: begin
          if (!req_s) begin
            region_cs  <= '0;
            default_cs <= 1'b0;
            state_r    <= ST_IDLE;
          end
        end
        default: begin
          region_cs  <= '0;
          default_cs <= 1'b0;
          ready      <= 1'b1;
          wait_cnt_r <= '0;
          state_r    <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_map_decoder.sv
// Bench for mem_map_decoder: directed vector table, reset-in-wait sequence,
// then randomized traffic against an access-level reference model.
module tb_mem_map_decoder;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] address = 16'h0000;
  logic        memread = 1'b0, memwrite = 1'b0, iowrite = 1'b0, mem_en = 1'b1;
  logic [7:0]  ioaddr = 8'h00;
  logic [2:0]  region_cs;
  logic        default_cs, ready, boot_shadow, write_fault;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clock = ~clock;

  mem_map_decoder dut (
    .clock(clock), .reset(reset), .address(address), .memread(memread),
    .memwrite(memwrite), .iowrite(iowrite), .ioaddr(ioaddr), .mem_en(mem_en),
    .region_cs(region_cs), .default_cs(default_cs), .ready(ready),
    .boot_shadow(boot_shadow), .write_fault(write_fault)
  );

  // {region_cs[2:0], default_cs, ready, write_fault, boot_shadow}
  function automatic logic [6:0] outs();
    return {region_cs, default_cs, ready, write_fault, boot_shadow};
  endfunction

  task automatic check(input string name, input logic [6:0] got, input logic [6:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got cs/def/rdy/flt/sh=%b expected %b at %0t", name, got, exp, $time);
  endtask

  task automatic drive(input logic rd, input logic wr, input logic en, input logic [15:0] a,
                       input logic iow, input logic [7:0] ioa);
    memread = rd; memwrite = wr; mem_en = en; address = a; iowrite = iow; ioaddr = ioa;
  endtask

  typedef struct {
    logic        rd, wr, en;
    logic [15:0] addr;
    logic        iow;
    logic [7:0]  ioa;
    logic [6:0]  exp;
  } vec_t;

  function automatic vec_t mk(input logic rd, input logic wr, input logic en, input logic [15:0] a,
                              input logic iow, input logic [7:0] ioa, input logic [6:0] exp);
    vec_t v;
    v.rd = rd; v.wr = wr; v.en = en; v.addr = a; v.iow = iow; v.ioa = ioa; v.exp = exp;
    return v;
  endfunction

  // Reference model: region table from the memory map, and an access seen as
  // "k cycles since start" with ready low while k <= W.
  int  ref_base[3] = '{15, 14, 0};
  int  ref_mask[3] = '{15, 15, 0};
  int  ref_wait[3] = '{1, 2, 0};
  bit  ref_ro[3]   = '{1'b1, 1'b0, 1'b0};
  bit  m_busy, m_fault, m_shadow;
  int  m_k, m_w, m_tgt;

  task automatic decode(input int top, input bit sh, input bit wr,
                        output int tgt, output int w, output bit f);
    int hit = -1;
    for (int i = 2; i >= 0; i--)
      if (ref_mask[i] != 0 && (top & ref_mask[i]) == (ref_base[i] & ref_mask[i])) hit = i;
    if (sh && top == 0) hit = 0;
    f = 1'b0;
    if (hit >= 0 && ref_ro[hit] && wr) begin tgt = -1; w = 0; f = 1'b1; end
    else if (hit >= 0) begin tgt = hit; w = ref_wait[hit]; end
    else begin tgt = 3; w = 0; end
  endtask

  task automatic model_reset();
    m_busy = 1'b0; m_fault = 1'b0; m_shadow = 1'b1; m_k = 0; m_w = 0; m_tgt = -1;
  endtask

  task automatic model_edge(input logic rd, input logic wr, input logic en, input logic [15:0] a,
                            input logic iow, input logic [7:0] ioa);
    bit req;
    req = (rd | wr) & en;
    m_fault = 1'b0;
    if (!m_busy) begin
      if (req) begin
        decode(int'(a[15:12]), m_shadow, wr, m_tgt, m_w, m_fault);
        m_busy = 1'b1;
        m_k = 1;
      end
    end else if (!req) m_busy = 1'b0;
    else m_k++;
    if (iow && ioa == 8'hFE) m_shadow = 1'b0;
  endtask

  function automatic logic [6:0] model_exp();
    logic [2:0] cs = 3'b000;
    logic       def = 1'b0;
    if (m_busy && m_tgt >= 0 && m_tgt <= 2) cs[m_tgt] = 1'b1;
    if (m_busy && m_tgt == 3) def = 1'b1;
    return {cs, def, !(m_busy && m_k <= m_w), m_fault, m_shadow};
  endfunction

  initial begin
    vec_t tbl[$];
    logic rd_v, wr_v, en_v, iow_v;
    logic [15:0] a_v;
    logic [7:0]  ioa_v;

    // idle cycle used as filler
    tbl.push_back(mk(1,0,1,16'h0123,0,8'h00,7'b001_0_0_0_1)); // shadow ROM, 1 wait
    tbl.push_back(mk(1,0,1,16'h0123,0,8'h00,7'b001_0_1_0_1));
    tbl.push_back(mk(0,0,1,16'h0000,0,8'h00,7'b000_0_1_0_1));
    tbl.push_back(mk(0,0,1,16'h0000,1,8'hFE,7'b000_0_1_0_0)); // OUT (FE)
    tbl.push_back(mk(1,0,1,16'h0123,0,8'h00,7'b000_1_1_0_0)); // now RAM
    tbl.push_back(mk(0,0,1,16'h0000,0,8'h00,7'b000_0_1_0_0));
    tbl.push_back(mk(1,0,1,16'hF800,0,8'h00,7'b001_0_0_0_0));
    tbl.push_back(mk(1,0,1,16'hF800,0,8'h00,7'b001_0_1_0_0));
    tbl.push_back(mk(0,0,1,16'h0000,0,8'h00,7'b000_0_1_0_0));
    tbl.push_back(mk(1,0,1,16'hE010,0,8'h00,7'b010_0_0_0_0)); // VGA, 2 waits
    tbl.push_back(mk(1,0,1,16'hE010,0,8'h00,7'b010_0_0_0_0));
    tbl.push_back(mk(1,0,1,16'hE010,0,8'h00,7'b010_0_1_0_0));
    tbl.push_back(mk(0,0,1,16'h0000,0,8'h00,7'b000_0_1_0_0));
    tbl.push_back(mk(0,1,1,16'hF000,0,8'h00,7'b000_0_1_1_0)); // write to ROM
    tbl.push_back(mk(0,1,1,16'hF000,0,8'h00,7'b000_0_1_0_0));
    tbl.push_back(mk(0,0,1,16'h0000,0,8'h00,7'b000_0_1_0_0));
    tbl.push_back(mk(1,0,1,16'hE000,0,8'h00,7'b010_0_0_0_0));
    tbl.push_back(mk(0,0,1,16'hE000,0,8'h00,7'b000_0_1_0_0)); // drop in WAIT
    tbl.push_back(mk(1,0,1,16'h4000,0,8'h00,7'b000_1_1_0_0));
    tbl.push_back(mk(0,0,1,16'h0000,0,8'h00,7'b000_0_1_0_0));
    tbl.push_back(mk(1,0,1,16'hE000,0,8'h00,7'b010_0_0_0_0)); // addr change mid-access
    tbl.push_back(mk(1,0,1,16'h1000,0,8'h00,7'b010_0_0_0_0));
    tbl.push_back(mk(1,0,1,16'h1000,0,8'h00,7'b010_0_1_0_0));
    tbl.push_back(mk(1,0,1,16'h1000,0,8'h00,7'b010_0_1_0_0));
    tbl.push_back(mk(0,0,1,16'h0000,0,8'h00,7'b000_0_1_0_0));
    tbl.push_back(mk(1,0,0,16'hE000,0,8'h00,7'b000_0_1_0_0)); // mem_en low
    tbl.push_back(mk(1,0,1,16'hE000,0,8'h00,7'b010_0_0_0_0));
    tbl.push_back(mk(1,0,0,16'hE000,0,8'h00,7'b000_0_1_0_0)); // mem_en falls in WAIT
    tbl.push_back(mk(0,0,1,16'h0000,0,8'h00,7'b000_0_1_0_0));
    tbl.push_back(mk(0,1,1,16'h4000,0,8'h00,7'b000_1_1_0_0)); // RAM write
    tbl.push_back(mk(0,0,1,16'h0000,0,8'h00,7'b000_0_1_0_0));

    repeat (2) @(posedge clock);
    #1;
    check("reset_values", outs(), 7'b000_0_1_0_1);
    reset = 1'b0;

    foreach (tbl[i]) begin
      drive(tbl[i].rd, tbl[i].wr, tbl[i].en, tbl[i].addr, tbl[i].iow, tbl[i].ioa);
      @(posedge clock); #1;
      check($sformatf("vec%0d", i), outs(), tbl[i].exp);
    end

    // Asynchronous reset in the middle of a VGA wait.
    drive(1, 0, 1, 16'hE000, 0, 8'h00);
    @(posedge clock); #1;
    check("wait_before_reset", outs(), 7'b010_0_0_0_0);
    reset = 1'b1;
    #1;
    check("async_reset_in_wait", outs(), 7'b000_0_1_0_1);
    drive(0, 0, 1, 16'h0000, 0, 8'h00);
    #1 reset = 1'b0;
    model_reset();

    rd_v = 1'b0; wr_v = 1'b0; a_v = 16'h0000;
    for (int n = 0; n < 3000; n++) begin
      if (rd_v | wr_v) begin
        if ($urandom_range(0, 99) < 25) begin rd_v = 1'b0; wr_v = 1'b0; end
        if ($urandom_range(0, 99) < 10) a_v = 16'($urandom);
      end else if ($urandom_range(0, 99) < 40) begin
        if ($urandom_range(0, 1) == 0) rd_v = 1'b1; else wr_v = 1'b1;
        case ($urandom_range(0, 3))
          0: a_v = {4'h0, 12'($urandom)};
          1: a_v = {4'hF, 12'($urandom)};
          2: a_v = {4'hE, 12'($urandom)};
          default: a_v = 16'($urandom);
        endcase
      end
      en_v  = ($urandom_range(0, 99) < 95);
      iow_v = ($urandom_range(0, 99) < 3);
      ioa_v = ($urandom_range(0, 1) == 0) ? 8'hFE : 8'($urandom);
      drive(rd_v, wr_v, en_v, a_v, iow_v, ioa_v);
      @(posedge clock); #1;
      model_edge(rd_v, wr_v, en_v, a_v, iow_v, ioa_v);
      check($sformatf("rand%0d", n), outs(), model_exp());
      if ($urandom_range(0, 999) < 5) begin
        reset = 1'b1;
        #1;
        model_reset();
        check($sformatf("rand_reset%0d", n), outs(), model_exp());
        reset = 1'b0;
      end
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
